// File: rtl/pac_score_ctrl.sv
// Pac-man game-rule stage: pellet bitmap, BCD score, lives and game phase, plus 7-seg word.
// Optional FREE_LIFE_EN: grant an extra life (max 3) whenever the score's thousands digit rolls.
module pac_score_ctrl #(
    parameter int unsigned TILE_SHIFT = 5,
    parameter int unsigned COLS       = 20,
    parameter int unsigned ROWS       = 15,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned HIT_DIST   = 16,
    parameter int unsigned HIT_TICKS  = 60
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        tick,
    input  logic        start,
    input  logic [9:0]  pac_x,
    input  logic [9:0]  pac_y,
    input  logic [9:0]  ghost_x,
    input  logic [8:0]  ghost_y,
    input  logic [4:0]  q_col,
    input  logic [3:0]  q_row,
    output logic        q_pellet,
    output logic [15:0] score_bcd,
    output logic [1:0]  lives,
    output logic [2:0]  phase,
    output logic [31:0] seg_data
);

    localparam int unsigned NumTiles = COLS * ROWS;
    localparam int unsigned CntW     = $clog2(NumTiles + 1);
    localparam int unsigned IdxW     = (NumTiles > 1) ? $clog2(NumTiles) : 1;
    localparam int unsigned HitW     = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StHit  = 3'd2,
        StOver = 3'd3,
        StWin  = 3'd4
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [NumTiles-1:0] pellets_q, pellets_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [15:0]         score_q, score_d;
    logic [1:0]          lives_q, lives_d;
    logic [HitW-1:0]     hit_q, hit_d;

    logic [9:0]      pac_col, pac_row, gy, dx, dy;
    logic            pac_in_grid, q_in_grid, eat, collide;
    logic [IdxW-1:0] pac_idx, q_idx;
    logic [15:0]     score_inc;

    assign pac_col     = pac_x >> TILE_SHIFT;
    assign pac_row     = pac_y >> TILE_SHIFT;
    assign pac_in_grid = (32'(pac_col) < COLS) && (32'(pac_row) < ROWS);
    assign pac_idx     = IdxW'(32'(pac_row) * COLS + 32'(pac_col));
    assign eat         = pac_in_grid && pellets_q[pac_idx];

    assign gy      = {1'b0, ghost_y};
    assign dx      = (pac_x >= ghost_x) ? (pac_x - ghost_x) : (ghost_x - pac_x);
    assign dy      = (pac_y >= gy) ? (pac_y - gy) : (gy - pac_y);
    assign collide = (32'(dx) < HIT_DIST) && (32'(dy) < HIT_DIST);

    assign q_in_grid = (32'(q_col) < COLS) && (32'(q_row) < ROWS);
    assign q_idx     = IdxW'(32'(q_row) * COLS + 32'(q_col));
    assign q_pellet  = q_in_grid && pellets_q[q_idx];

`ifdef FREE_LIFE_EN
    logic free_life;
    // Thousands digit rolls exactly when tens and hundreds are both 9 (and not saturated).
    assign free_life = (score_q != 16'h9990) && (score_q[11:4] == 8'h99);
`endif

    // Score only ever grows by 10: BCD step on digit1 with ripple into digits 2 and 3.
    always_comb begin
        score_inc = score_q;
        if (score_q != 16'h9990) begin
            if (score_q[7:4] == 4'd9) begin
                score_inc[7:4] = 4'd0;
                if (score_q[11:8] == 4'd9) begin
                    score_inc[11:8]  = 4'd0;
                    score_inc[15:12] = score_q[15:12] + 4'd1;
                end else begin
                    score_inc[11:8] = score_q[11:8] + 4'd1;
                end
            end else begin
                score_inc[7:4] = score_q[7:4] + 4'd1;
            end
        end
    end

    always_comb begin
        phase_d   = phase_q;
        pellets_d = pellets_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        lives_d   = lives_q;
        hit_d     = hit_q;
        if (tick) begin
            case (phase_q)
                StIdle, StOver, StWin: begin
                    if (start) begin
                        pellets_d = '1;
                        cnt_d     = CntW'(NumTiles);
                        score_d   = '0;
                        lives_d   = 2'(LIVES);
                        phase_d   = StPlay;
                    end
                end
                StPlay: begin
                    if (eat) begin
                        pellets_d[pac_idx] = 1'b0;
                        cnt_d              = cnt_q - CntW'(1);
                        score_d            = score_inc;
`ifdef FREE_LIFE_EN
                        if (free_life && lives_q != 2'd3) lives_d = lives_q + 2'd1;
`endif
                    end
                    // Clearing the last pellet wins outright and masks a same-tick collision.
                    if (eat && cnt_q == CntW'(1)) begin
                        phase_d = StWin;
                    end else if (collide) begin
                        lives_d = lives_d - 2'd1;
                        hit_d   = HitW'(HIT_TICKS - 1);
                        phase_d = StHit;
                    end
                end
                StHit: begin
                    if (hit_q == '0) begin
                        phase_d = (lives_q == 2'd0) ? StOver : StPlay;
                    end else begin
                        hit_d = hit_q - HitW'(1);
                    end
                end
                default: phase_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            phase_q   <= StIdle;
            pellets_q <= '1;
            cnt_q     <= CntW'(NumTiles);
            score_q   <= '0;
            lives_q   <= 2'(LIVES);
            hit_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            pellets_q <= pellets_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
        end
    end

    assign score_bcd = score_q;
    assign lives     = lives_q;
    assign phase     = phase_q;
    assign seg_data  = {score_q, 4'h0, 2'b00, lives_q, 4'h0, 1'b0, phase_q};

endmodule
